uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DATA_BITS, default 8, number of data bits per frame (5..9).
REQ-002 Parameter: OVERSAMPLE, default 16, sample_tick pulses per bit period (even, >=8).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sample_tick  input  1  single-clk pulse at OVERSAMPLE x baud rate; all bit timing is counted in these ticks only.
REQ-006 rx_pin  input  1  asynchronous serial line; idle high.
REQ-007 parity_enable  input  1  when high, frame carries one odd-parity bit after the data bits.
REQ-008 rx_data  output  DATA_BITS  last received word, LSB received first.
REQ-009 rx_valid  output  1  one-clk pulse; rx_data and the error flags are valid in that cycle.
REQ-010 parity_error  output  1  received parity bit does not equal ~^rx_data; held until the next rx_valid.
REQ-011 framing_error  output  1  stop bit sampled low; held until the next rx_valid.
REQ-012 rx_busy  output  1  high from start-bit detection until return to IDLE.

Function
REQ-013 rx_pin shall pass through a two-flop synchronizer; all decoding uses the synchronized value (rx_s).
REQ-014 States: IDLE, START, DATA, PARITY, STOP; no other state is reachable, and any illegal encoding returns to IDLE.
REQ-015 IDLE: on a high-to-low transition of rx_s, go to START, clear tick counter, assert rx_busy, latch parity_enable for the frame.
REQ-016 A line held low since reset or since the previous frame shall not trigger a start; only a falling edge does.
REQ-017 START: on the (OVERSAMPLE/2)th sample_tick, sample rx_s; if high (glitch), return to IDLE with rx_busy low and no rx_valid; if low, clear counter, bit_index=0, go to DATA.
REQ-018 DATA: every OVERSAMPLE sample_ticks, sample rx_s into bit position bit_index (LSB first); after bit DATA_BITS-1, go to PARITY if latched parity_enable, else STOP.
REQ-019 PARITY: after OVERSAMPLE ticks, sample parity bit; parity error if sampled bit != ~^(received data); go to STOP.
REQ-020 STOP: after OVERSAMPLE ticks, sample rx_s; low sets framing error.
REQ-021 In the clk cycle after the stop sample, rx_data, parity_error, framing_error update together, rx_valid pulses for exactly one clk, rx_busy falls, state returns to IDLE.
REQ-022 A frame with a framing error shall still deliver rx_data and rx_valid.
REQ-023 Latency: rx_valid asserts one clk after the sample_tick that samples the stop bit.
REQ-024 rx_pin transitions between sample points shall have no effect; only mid-bit samples matter.
REQ-025 Changes to parity_enable during a frame shall not affect that frame.
REQ-026 Tick counter width shall be $clog2(OVERSAMPLE); bit_index width $clog2(DATA_BITS), compared without truncation.

Reset
REQ-027 While reset is high: rx_data=0, rx_valid=0, parity_error=0, framing_error=0, rx_busy=0, state=IDLE, synchronizer flops=1, counters=0.
REQ-028 Reset asserted mid-frame aborts the frame with no rx_valid; after release, a start requires a new falling edge.

Structure
REQ-029 State enum (IDLE..STOP) shall live in shared package uart_pkg, also used by the transmitter.
REQ-030 The two-flop synchronizer shall be sub-module sync_2ff (reset value parameterized, here 1).

Verification
REQ-031 Default parameters, parity off, frame 0xA5 with sample_tick every 4 clks -> one rx_valid, rx_data=0xA5, both error flags 0.
REQ-032 Parity on, data 0x03 with parity bit 1 -> rx_data=0x03, parity_error=0; same data with parity bit 0 -> parity_error=1.
REQ-033 Stop bit driven low, data 0x5A -> rx_valid with rx_data=0x5A, framing_error=1; line held low afterward -> no further rx_valid.
REQ-034 Low pulse on rx_pin of 3 sample_ticks -> no rx_valid, rx_busy returns to 0 by tick 8.
REQ-035 Loopback with the transmitter driven by a /16 baud tick, 256 back-to-back words 0x00..0xFF, parity on -> all received in order, no errors.
REQ-036 Reset asserted in the middle of the DATA state -> all outputs 0, no rx_valid; next clean frame 0x3C received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter frame state encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, configurable reset value.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/optional odd parity/stop, mid-bit sampling.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx_pin,
    input  logic                 parity_enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 rx_busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_t          state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par_en_q, par_en_n;
    logic                 par_flag, par_flag_n;
    logic [DATA_BITS-1:0] rx_data_n;
    logic                 rx_valid_n, parity_error_n, framing_error_n, rx_busy_n;
    logic                 rx_s, rx_prev;
    logic [1:0]           settle;
    logic                 fall;

    sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_pin),
        .q     (rx_s)
    );

    // Edge detector stays disarmed until the synchronizer has flushed its reset value,
    // so a line held low through reset never looks like a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle  <= 2'b00;
            rx_prev <= 1'b0;
        end else begin
            settle  <= {settle[0], 1'b1};
            rx_prev <= settle[1] ? rx_s : 1'b0;
        end
    end

    assign fall = rx_prev & ~rx_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            par_en_q      <= 1'b0;
            par_flag      <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bit_idx       <= bit_idx_n;
            shift         <= shift_n;
            par_en_q      <= par_en_n;
            par_flag      <= par_flag_n;
            rx_data       <= rx_data_n;
            rx_valid      <= rx_valid_n;
            parity_error  <= parity_error_n;
            framing_error <= framing_error_n;
            rx_busy       <= rx_busy_n;
        end
    end

    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        bit_idx_n       = bit_idx;
        shift_n         = shift;
        par_en_n        = par_en_q;
        par_flag_n      = par_flag;
        rx_data_n       = rx_data;
        rx_valid_n      = 1'b0;
        parity_error_n  = parity_error;
        framing_error_n = framing_error;
        rx_busy_n       = rx_busy;

        case (state)
            IDLE: begin
                if (fall) begin
                    state_n    = START;
                    cnt_n      = '0;
                    rx_busy_n  = 1'b1;
                    par_en_n   = parity_enable;
                    par_flag_n = 1'b0;
                end
            end
            START: begin
                if (sample_tick) begin
                    if (cnt == HALF_CNT) begin
                        if (rx_s) begin
                            state_n   = IDLE;
                            rx_busy_n = 1'b0;
                        end else begin
                            state_n   = DATA;
                            cnt_n     = '0;
                            bit_idx_n = '0;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (cnt == FULL_CNT) begin
                        cnt_n            = '0;
                        shift_n[bit_idx] = rx_s;
                        if (bit_idx == LAST_IDX) begin
                            state_n = par_en_q ? PARITY : STOP;
                        end else begin
                            bit_idx_n = bit_idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (sample_tick) begin
                    if (cnt == FULL_CNT) begin
                        cnt_n      = '0;
                        par_flag_n = (rx_s != ~^shift);
                        state_n    = STOP;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (sample_tick) begin
                    if (cnt == FULL_CNT) begin
                        cnt_n           = '0;
                        state_n         = IDLE;
                        rx_data_n       = shift;
                        rx_valid_n      = 1'b1;
                        parity_error_n  = par_flag;
                        framing_error_n = ~rx_s;
                        rx_busy_n       = 1'b0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n   = IDLE;
                rx_busy_n = 1'b0;
            end
        endcase
    end

endmodule
